// File: rtl/hub75_scan_ctrl.sv
// hub75_scan_ctrl: scan controller for HUB75 LED matrix panels.
// Fetches one scan row of pixels, shifts it into the panel, blanks, latches,
// then holds the row lit for a plane-weighted time. Rows are scanned in turn.
// Build option HUB75_BCM_EN: when defined, every colour bit plane is shifted
// and displayed with binary-weighted on-time (binary-code modulation). When
// undefined, only the most significant plane is shown.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | panel dark, waiting for en_i
// SHIFT   | 2*COLS+1 cycles: fetch pixel, present colour bits, pulse sclk
// BLANK   | BLANK_CYC cycles dark after shifting, row address switched
// LATCH   | one-cycle latch pulse transferring shifted data to drivers
// DISPLAY | output enabled for BASE_ON<<plane cycles
module hub75_scan_ctrl #(
   parameter int  COLS      = 64,
   parameter int  ROW_BITS  = 4,
   parameter int  CDEPTH    = 4,
   parameter int  BASE_ON   = 8,
   parameter int  BLANK_CYC = 2,
   localparam int COL_W     = $clog2(COLS)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  en_i,
   output logic [ROW_BITS-1:0]   pix_row_o,
   output logic [COL_W-1:0]      pix_col_o,
   input  logic [6*CDEPTH-1:0]   pix_data_i,
   output logic [ROW_BITS-1:0]   addr_o,
   output logic                  r0_o,
   output logic                  g0_o,
   output logic                  b0_o,
   output logic                  r1_o,
   output logic                  g1_o,
   output logic                  b1_o,
   output logic                  sclk_o,
   output logic                  lat_o,
   output logic                  oe_o,
   output logic                  frame_done_o
);

   localparam int PLANE_W    = (CDEPTH > 1) ? $clog2(CDEPTH) : 1;
   localparam int SHIFT_LAST = 2 * COLS;
   localparam int SIDX_W     = $clog2(SHIFT_LAST + 1);
   localparam int DISP_MAX   = BASE_ON << (CDEPTH - 1);
   localparam int TMR_MAX    = (DISP_MAX > BLANK_CYC) ? DISP_MAX : BLANK_CYC;
   localparam int TMR_W      = $clog2(TMR_MAX + 1);

   localparam logic [PLANE_W-1:0]  PLANE_LAST = PLANE_W'(CDEPTH - 1);
`ifdef HUB75_BCM_EN
   localparam logic [PLANE_W-1:0]  PLANE_FIRST = '0;
`else
   localparam logic [PLANE_W-1:0]  PLANE_FIRST = PLANE_LAST;
`endif
   localparam logic [ROW_BITS-1:0] ROW_LAST   = '1;
   localparam logic [COL_W-1:0]    COL_LAST   = COL_W'(COLS - 1);
   localparam logic [SIDX_W-1:0]   SIDX_LAST  = SIDX_W'(SHIFT_LAST);
   localparam logic [TMR_W-1:0]    BLANK_LOAD = TMR_W'(BLANK_CYC - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_BLANK,
      ST_LATCH,
      ST_DISPLAY
   } state_t;

   state_t               state_q;
   logic [ROW_BITS-1:0]  row_q;
   logic [PLANE_W-1:0]   plane_q;
   logic [SIDX_W-1:0]    sidx_q;
   logic [TMR_W-1:0]     tmr_q;
   logic [ROW_BITS-1:0]  pix_row_q;
   logic [COL_W-1:0]     pix_col_q;
   logic [ROW_BITS-1:0]  addr_q;
   logic [5:0]           rgb_q;
   logic                 sclk_q;
   logic                 lat_q;
   logic                 oe_q;
   logic                 fd_q;

   logic [6*CDEPTH-1:0]  pix_shr_d;
   logic [5:0]           plane_bits_d;
   logic [TMR_W-1:0]     disp_load_d;
   logic                 last_plane_d;
   logic [ROW_BITS-1:0]  row_inc_d;

   // Pick bit[plane] out of each colour field, packed as {r0,g0,b0,r1,g1,b1}.
   always_comb begin
      pix_shr_d    = pix_data_i >> plane_q;
      plane_bits_d = {pix_shr_d[5*CDEPTH], pix_shr_d[4*CDEPTH], pix_shr_d[3*CDEPTH],
                      pix_shr_d[2*CDEPTH], pix_shr_d[CDEPTH],   pix_shr_d[0]};
   end

   // Display length for the current plane, and row/plane sequencing helpers.
   always_comb begin
      disp_load_d = TMR_W'((BASE_ON << plane_q) - 1);
      row_inc_d   = row_q + 1'b1;
`ifdef HUB75_BCM_EN
      last_plane_d = (plane_q == PLANE_LAST);
`else
      last_plane_d = 1'b1;
`endif
   end

   // Scan sequencer; every panel and fetch output is a register set here.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         row_q     <= '0;
         plane_q   <= PLANE_FIRST;
         sidx_q    <= '0;
         tmr_q     <= '0;
         pix_row_q <= '0;
         pix_col_q <= '0;
         addr_q    <= '0;
         rgb_q     <= '0;
         sclk_q    <= 1'b0;
         lat_q     <= 1'b0;
         oe_q      <= 1'b1;
         fd_q      <= 1'b0;
      end else begin
         sclk_q <= 1'b0;
         lat_q  <= 1'b0;
         fd_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               oe_q <= 1'b1;
               if (en_i) begin
                  state_q   <= ST_SHIFT;
                  sidx_q    <= '0;
                  pix_row_q <= row_q;
                  pix_col_q <= '0;
               end
            end
            ST_SHIFT: begin
               if (sidx_q == SIDX_LAST) begin
                  state_q <= ST_BLANK;
                  tmr_q   <= BLANK_LOAD;
                  addr_q  <= row_q;
               end else begin
                  sidx_q <= sidx_q + 1'b1;
                  // Odd cycle: fetched data is valid now; present it and clock it in next cycle.
                  if (sidx_q[0]) begin
                     rgb_q  <= plane_bits_d;
                     sclk_q <= 1'b1;
                     if (pix_col_q != COL_LAST) begin
                        pix_col_q <= pix_col_q + 1'b1;
                     end
                  end
               end
            end
            ST_BLANK: begin
               if (tmr_q == '0) begin
                  state_q <= ST_LATCH;
                  lat_q   <= 1'b1;
               end else begin
                  tmr_q <= tmr_q - 1'b1;
               end
            end
            ST_LATCH: begin
               state_q <= ST_DISPLAY;
               oe_q    <= 1'b0;
               tmr_q   <= disp_load_d;
            end
            ST_DISPLAY: begin
               if (tmr_q == '0) begin
                  oe_q      <= 1'b1;
                  sidx_q    <= '0;
                  pix_col_q <= '0;
                  if (!last_plane_d) begin
                     plane_q   <= plane_q + 1'b1;
                     pix_row_q <= row_q;
                     state_q   <= ST_SHIFT;
                  end else begin
                     plane_q <= PLANE_FIRST;
                     fd_q    <= (row_q == ROW_LAST);
                     // en_i only matters at a row boundary so a row is never cut short.
                     if (en_i) begin
                        row_q     <= row_inc_d;
                        pix_row_q <= row_inc_d;
                        state_q   <= ST_SHIFT;
                     end else begin
                        row_q     <= '0;
                        pix_row_q <= '0;
                        addr_q    <= '0;
                        state_q   <= ST_IDLE;
                     end
                  end
               end else begin
                  tmr_q <= tmr_q - 1'b1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               oe_q    <= 1'b1;
            end
         endcase
      end
   end

   assign pix_row_o    = pix_row_q;
   assign pix_col_o    = pix_col_q;
   assign addr_o       = addr_q;
   assign r0_o         = rgb_q[5];
   assign g0_o         = rgb_q[4];
   assign b0_o         = rgb_q[3];
   assign r1_o         = rgb_q[2];
   assign g1_o         = rgb_q[1];
   assign b1_o         = rgb_q[0];
   assign sclk_o       = sclk_q;
   assign lat_o        = lat_q;
   assign oe_o         = oe_q;
   assign frame_done_o = fd_q;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Scoreboard bench for hub75_scan_ctrl with a small panel configuration.
// Expected panel events (sclk edges with colour, latches, OE-low bursts,
// frame pulses) are queued by the stimulus; a monitor pops and compares.
module tb_hub75_scan_ctrl;

   localparam int COLS      = 4;
   localparam int ROW_BITS  = 1;
   localparam int CDEPTH    = 2;
   localparam int BASE_ON   = 2;
   localparam int BLANK_CYC = 1;
   localparam int DW        = 6 * CDEPTH;
`ifdef HUB75_BCM_EN
   localparam int P_FIRST   = 0;
   localparam int FRAME_CYC = 56;
`else
   localparam int P_FIRST   = CDEPTH - 1;
   localparam int FRAME_CYC = 30;
`endif

   localparam int EV_SCLK = 0;
   localparam int EV_LAT  = 1;
   localparam int EV_OE   = 2;
   localparam int EV_FD   = 3;

   localparam logic [13:0] RESET_OUTS = 14'b00_0000_0000_0010;

   typedef struct {
      int kind;
      int data;
      bit chk;
   } ev_t;

   ev_t exp_q[$];
   int  checks = 0;
   int  errors = 0;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          en_i = 1'b0;
   logic [0:0]    pix_row_o;
   logic [1:0]    pix_col_o;
   logic [DW-1:0] pix_data_i;
   logic [0:0]    addr_o;
   logic          r0_o, g0_o, b0_o, r1_o, g1_o, b1_o;
   logic          sclk_o, lat_o, oe_o, frame_done_o;

   logic [DW-1:0] pix_const = '0;
   int            pix_mode = 0;
   bit            mon_en = 1'b0;

   logic [5:0]    rgb_now;
   logic [13:0]   outs_now;
   assign rgb_now  = {r0_o, g0_o, b0_o, r1_o, g1_o, b1_o};
   assign outs_now = {pix_row_o, pix_col_o, addr_o, rgb_now, sclk_o, lat_o, oe_o, frame_done_o};

   hub75_scan_ctrl #(
      .COLS      (COLS),
      .ROW_BITS  (ROW_BITS),
      .CDEPTH    (CDEPTH),
      .BASE_ON   (BASE_ON),
      .BLANK_CYC (BLANK_CYC)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .en_i         (en_i),
      .pix_row_o    (pix_row_o),
      .pix_col_o    (pix_col_o),
      .pix_data_i   (pix_data_i),
      .addr_o       (addr_o),
      .r0_o         (r0_o),
      .g0_o         (g0_o),
      .b0_o         (b0_o),
      .r1_o         (r1_o),
      .g1_o         (g1_o),
      .b1_o         (b1_o),
      .sclk_o       (sclk_o),
      .lat_o        (lat_o),
      .oe_o         (oe_o),
      .frame_done_o (frame_done_o)
   );

   always #5 clk_i = ~clk_i;

   // Pixel source: constant word, or a row/column dependent pattern.
   function automatic logic [DW-1:0] pix_word(input int mode, input logic [0:0] r, input logic [1:0] c);
      if (mode == 0) return pix_const;
      return {c, ~c, {r, ~r}, c ^ 2'b10, {c[0], r}, 2'b10};
   endfunction

   // Synchronous pixel memory: data valid one cycle after the address.
   always @(posedge clk_i) pix_data_i <= pix_word(pix_mode, pix_row_o, pix_col_o);

   // Colour bits expected on the panel for plane p: {r0,g0,b0,r1,g1,b1}.
   function automatic int exp_rgb(input logic [DW-1:0] d, input int p);
      logic [5:0] v;
      for (int k = 0; k < 6; k++) v[k] = d[k*CDEPTH + p];
      return int'(v);
   endfunction

   function automatic string kname(input int k);
      case (k)
         EV_SCLK: return "sclk_edge";
         EV_LAT:  return "latch";
         EV_OE:   return "oe_low_len";
         default: return "frame_done";
      endcase
   endfunction

   task automatic push(input int kind, input int data, input bit chk);
      ev_t e;
      e.kind = kind;
      e.data = data;
      e.chk  = chk;
      exp_q.push_back(e);
   endtask

   task automatic push_row(input int r);
      for (int p = P_FIRST; p < CDEPTH; p++) begin
         for (int c = 0; c < COLS; c++)
            push(EV_SCLK, exp_rgb(pix_word(pix_mode, 1'(r), 2'(c)), p), 1'b1);
         push(EV_LAT, r, 1'b1);
         push(EV_OE, BASE_ON << p, 1'b1);
      end
   endtask

   task automatic push_frame(input bit chk_period);
      push_row(0);
      push_row(1);
      push(EV_FD, FRAME_CYC, chk_period);
   endtask

   task automatic take(input int kind, input int data);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_%s: got data %0d, expected no event", kname(kind), data);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || (e.chk && e.data != data)) begin
            errors++;
            $display("FAIL %s: got %s data %0d, expected %s data %0d",
                     kname(e.kind), kname(kind), data, kname(e.kind), e.data);
         end
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out waiting", name);
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk_i);
   endtask

   task automatic wait_row1(input string name);
      int n;
      n = 0;
      while (pix_row_o !== 1'b1 && n < 400) begin
         @(negedge clk_i);
         n++;
      end
      if (n >= 400) timeout(name);
   endtask

   task automatic wait_fd(input string name);
      int n;
      n = 0;
      while (frame_done_o !== 1'b1 && n < 400) begin
         @(negedge clk_i);
         n++;
      end
      if (n >= 400) timeout(name);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < 600) begin
         @(negedge clk_i);
         n++;
      end
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL %s: %0d expected events never seen", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic check_idle(input string tag);
      cycles(5);
      check({tag, "_oe"}, oe_o, 1);
      check({tag, "_addr"}, addr_o, 0);
      check({tag, "_pix_row"}, pix_row_o, 0);
      check({tag, "_sclk"}, sclk_o, 0);
   endtask

   // Monitor: turns output activity into events and scores them.
   initial begin : monitor
      bit p_sclk, p_lat;
      int oe_run, cnt;
      p_sclk = 1'b0;
      p_lat  = 1'b0;
      oe_run = 0;
      cnt    = 0;
      forever begin
         @(negedge clk_i);
         if (!rst_ni || !mon_en) begin
            p_sclk = sclk_o;
            p_lat  = lat_o;
            oe_run = 0;
            cnt    = 0;
         end else begin
            cnt++;
            if (sclk_o && !p_sclk) take(EV_SCLK, int'(rgb_now));
            if (lat_o && !p_lat) take(EV_LAT, int'(addr_o));
            if (!oe_o) oe_run++;
            else if (oe_run > 0) begin
               take(EV_OE, oe_run);
               oe_run = 0;
            end
            if (frame_done_o) begin
               take(EV_FD, cnt);
               cnt = 0;
            end
            p_sclk = sclk_o;
            p_lat  = lat_o;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int zeros, n;

      // Reset and idle behaviour.
      rst_ni = 1'b0;
      en_i   = 1'b0;
      cycles(3);
      check("reset_outputs", outs_now, RESET_OUTS);
      rst_ni = 1'b1;
      mon_en = 1'b1;
      cycles(6);
      check("idle_no_enable", outs_now, RESET_OUTS);

      // Two frames of r0=2'b11, enable dropped during the second frame's row 1.
      pix_mode  = 0;
      pix_const = 12'hC00;
      push_frame(1'b0);
      push_frame(1'b1);
      en_i = 1'b1;
      wait_fd("first_frame_done");
      wait_row1("frame2_row1");
      cycles(2);
      en_i = 1'b0;
      drain("frame_c00");
      check_idle("idle_after_c00");

      // Colours hold while idle; then distinct per-plane bits.
      check("rgb_hold_idle", rgb_now, exp_rgb(12'hC00, CDEPTH - 1));
      pix_const = 12'h6C6;
      push_frame(1'b0);
      en_i = 1'b1;
      wait_row1("frame_6c6_row1");
      cycles(2);
      en_i = 1'b0;
      drain("frame_6c6");
      check_idle("idle_after_6c6");
      check("rgb_hold_after", rgb_now, exp_rgb(12'h6C6, CDEPTH - 1));

      // Column/row dependent pixels from the memory model.
      pix_mode = 1;
      push_frame(1'b0);
      en_i = 1'b1;
      wait_row1("frame_mem_row1");
      cycles(2);
      en_i = 1'b0;
      drain("frame_mem");
      check_idle("idle_after_mem");

      // Reset held three cycles in the middle of DISPLAY.
      mon_en = 1'b0;
      en_i   = 1'b1;
      n = 0;
      while (oe_o !== 1'b0 && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      if (n >= 200) timeout("reach_display");
      rst_ni = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         check($sformatf("reset_hold_%0d", i), outs_now, RESET_OUTS);
      end
      exp_q.delete();
      push_frame(1'b0);
      mon_en = 1'b1;
      rst_ni = 1'b1;
      zeros = 0;
      n = 0;
      while (n < 20) begin
         @(negedge clk_i);
         n++;
         if (sclk_o) break;
         zeros++;
      end
      check("first_sclk_latency", zeros, 2);
      wait_row1("after_reset_row1");
      cycles(2);
      en_i = 1'b0;
      drain("frame_after_reset");
      check_idle("idle_after_reset");

      cycles(5);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
